cvxif_offload_ctrl: RTL and testbench
=====================================

# cvxif_offload_ctrl

Core-side initiator for the CV-X-IF issue, commit and result channels. Takes one decoded candidate instruction at a time from the core's issue stage and offers it to the coprocessor with its source operands. It then interprets the coprocessor's accept/writeback/register_read response, emits the matching commit transaction, and tracks outstanding writeback IDs in a scoreboard. Coprocessor results are routed back to the core writeback port, or flagged as errors.

## Interface
- XLEN, 32, operand and result width
- NrRs, 3, number of source operand ports (width of register_read)
- IdWidth, 3, transaction ID width; 2^IdWidth outstanding writebacks max
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- instr_valid_i  in  1  candidate instruction valid
- instr_ready_o  out  1  controller can take a candidate
- instr_i  in  32  instruction word
- rs_i  in  NrRs*XLEN  source operands, rs1 in LSBs
- flush_i  in  1  kill the in-flight candidate (speculation lost)
- x_issue_valid_o / x_issue_ready_i  out/in  1  issue handshake
- x_issue_instr_o  out  32  registered instruction
- x_issue_id_o  out  IdWidth  transaction ID
- x_issue_rs_o  out  NrRs*XLEN  registered operands
- x_issue_rs_valid_o  out  NrRs  all ones while x_issue_valid_o
- x_issue_accept_i, x_issue_writeback_i  in  1  issue response
- x_issue_register_read_i  in  NrRs  operands consumed (informational, counted only)
- x_commit_valid_o  out  1  commit pulse
- x_commit_id_o  out  IdWidth  committed ID
- x_commit_kill_o  out  1  commit kills the instruction
- x_result_valid_i / x_result_ready_o  in/out  1  result handshake; ready constantly 1 out of reset
- x_result_id_i  in  IdWidth, x_result_data_i  in  XLEN, x_result_rd_i  in  5, x_result_we_i  in  1
- wb_valid_o  out  1, wb_data_o  out  XLEN, wb_rd_o  out  5, wb_id_o  out  IdWidth  core writeback (no backpressure)
- illegal_o  out  1  one-cycle pulse: coprocessor rejected instruction
- result_err_o  out  1  one-cycle pulse: result with ID not outstanding

## Operation
- FSM states: IDLE, REQ, COMMIT.
- IDLE:
  - instr_ready_o = !busy[id_q].
  - On instr_valid_i && instr_ready_o: capture instr_i/rs_i, latch kill_q = 0, go REQ.
- REQ:
  - x_issue_valid_o = 1; instr, ID and operands are held stable until x_issue_ready_i. Valid is never retracted, even on flush.
  - flush_i in REQ sets kill_q.
  - On handshake with accept=1: go COMMIT. If writeback=1 && !kill_q && !flush_i, set busy[id_q] and store nothing else.
  - On handshake with accept=0: pulse illegal_o (suppressed if killed), return to IDLE, id_q unchanged.
- COMMIT:
  - x_commit_valid_o = 1 for exactly one cycle, with x_commit_id_o = id_q and x_commit_kill_o = kill_q | flush_i.
  - id_q increments mod 2^IdWidth; go IDLE.
- Results, accepted every cycle:
  - If busy[x_result_id_i]: clear it. If x_result_we_i, drive wb_* registered next cycle.
  - If x_result_id_i is not busy: pulse result_err_o next cycle and produce no writeback.
- Same-cycle set of busy[a] and clear of busy[b]: both take effect. Set and clear of the same ID cannot coincide, because an ID is only issued when not busy.
- A result with we=0 clears the entry silently.

## Timing
- Reset (any cycle): state IDLE, id_q = 0, busy = 0, kill_q = 0. All outputs are 0 except x_result_ready_o, which goes to 1 one cycle after reset release. Pending transactions are dropped; late results after reset produce result_err_o.
- Best-case candidate throughput: accept at cycle 0, x_issue_valid_o at cycle 1 (ready same cycle), commit at cycle 2, instr_ready_o at cycle 3, i.e. one instruction per 3 cycles.
- Result to wb_valid_o: 1 cycle. result_err_o: 1 cycle after the offending result.
- instr_ready_o is 0 in REQ and COMMIT.
- instr_ready_o is also 0 in IDLE while busy[id_q]. It rises the cycle after the result freeing that ID.

## Structure
- Package cvxif_offload_pkg: offload_state_t enum (IDLE, REQ, COMMIT); scoreboard entry struct; IdWidth default constant.
- Sub-module cvxif_offload_sb: 2^IdWidth busy bits with set/clear ports and a lookup for the result ID.
- Top module holds the FSM, request registers, commit logic and writeback registers.

## Test plan
- Custom add, accept=1, writeback=1, ready at once; result id 0, data 0x0000_0007, rd 5 two cycles later -> commit id 0 kill 0 at cycle 2; wb_valid_o with data 7, rd 5, id 0 one cycle after the result.
- Issue with accept=0 -> illegal_o pulse once; commit still carries kill=0 only if accepted, so here no commit; next candidate reuses id 0.
- flush_i asserted in REQ while ready is held low 3 cycles -> x_issue_valid_o held until ready; commit kill=1; no busy bit set; no illegal_o.
- Eight writeback instructions issued with no results -> instr_ready_o low with id_q=0. Result id 0 frees it and instr_ready_o rises the next cycle; id wraps 7 -> 0.
- Result id 3 with no outstanding entry -> result_err_o single pulse, wb_valid_o stays 0.
- rst_i asserted during REQ with 2 IDs busy -> all outputs 0 immediately; after release, a result for an old ID gives result_err_o.

Source files
------------

// File: rtl/cvxif_offload_pkg.sv
// ---------------------------------------------------------------------------
// cvxif_offload_pkg
// Shared types for the CV-X-IF offload controller.
//   offload_state_t : issue FSM state (IDLE, REQ, COMMIT)
//   sb_entry_t      : one writeback scoreboard entry
//   IdWidthDefault  : default transaction ID width
// ---------------------------------------------------------------------------
package cvxif_offload_pkg;

    localparam int IdWidthDefault = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        COMMIT = 2'd2
    } offload_state_t;

    // An entry only records that a writeback is outstanding for its ID;
    // the destination register arrives with the result itself.
    typedef struct packed {
        logic busy;
    } sb_entry_t;

endpackage

// File: rtl/cvxif_offload_sb.sv
// ---------------------------------------------------------------------------
// cvxif_offload_sb
// Outstanding-writeback scoreboard: one busy bit per transaction ID.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   set_en, set_id       : mark an ID as outstanding
//   clr_en, clr_id       : retire an ID (result received)
//   query_id/query_busy  : busy state of the ID the issue side wants next
//   lookup_id/lookup_busy: busy state of the ID carried by a result
// Lookups see the state before this cycle's set/clear.
// ---------------------------------------------------------------------------
module cvxif_offload_sb
    import cvxif_offload_pkg::*;
#(
    parameter int IdWidth = IdWidthDefault
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [IdWidth-1:0] set_id,
    input  logic               clr_en,
    input  logic [IdWidth-1:0] clr_id,
    input  logic [IdWidth-1:0] query_id,
    output logic               query_busy,
    input  logic [IdWidth-1:0] lookup_id,
    output logic               lookup_busy
);

    localparam int Depth = 1 << IdWidth;

    sb_entry_t entry_reg [Depth];

    // Each entry is its own flop so a set of one ID and a clear of another
    // in the same cycle both land. Set and clear of the same ID never
    // coincide because an ID is only issued while it is free.
    genvar gi;
    generate
        for (gi = 0; gi < Depth; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg[gi] <= '0;
                end else if (clr_en && (clr_id == IdWidth'(gi))) begin
                    entry_reg[gi].busy <= 1'b0;
                end else if (set_en && (set_id == IdWidth'(gi))) begin
                    entry_reg[gi].busy <= 1'b1;
                end
            end
        end
    endgenerate

    assign query_busy  = entry_reg[query_id].busy;
    assign lookup_busy = entry_reg[lookup_id].busy;

endmodule

// File: rtl/cvxif_offload_ctrl.sv
// ---------------------------------------------------------------------------
// cvxif_offload_ctrl
// Core-side CV-X-IF initiator. Takes one candidate instruction at a time,
// offers it on the issue channel, emits the commit, tracks outstanding
// writeback IDs and routes results back to the core writeback port.
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   instr_valid_i/instr_ready_o  : candidate handshake from the issue stage
//   instr_i, rs_i, flush_i       : candidate word, operands, speculation kill
//   x_issue_*                    : issue request/response channel
//   x_commit_*                   : one-cycle commit transaction
//   x_result_*                   : result channel (always ready after reset)
//   wb_*                         : core writeback, one cycle after a result
//   illegal_o                    : pulse when the coprocessor rejects
//   result_err_o                 : pulse when a result ID is not outstanding
// ---------------------------------------------------------------------------
module cvxif_offload_ctrl
    import cvxif_offload_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NrRs    = 3,
    parameter int IdWidth = IdWidthDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [31:0]          instr_i,
    input  logic [NrRs*XLEN-1:0] rs_i,
    input  logic                 flush_i,
    output logic                 x_issue_valid_o,
    input  logic                 x_issue_ready_i,
    output logic [31:0]          x_issue_instr_o,
    output logic [IdWidth-1:0]   x_issue_id_o,
    output logic [NrRs*XLEN-1:0] x_issue_rs_o,
    output logic [NrRs-1:0]      x_issue_rs_valid_o,
    input  logic                 x_issue_accept_i,
    input  logic                 x_issue_writeback_i,
    input  logic [NrRs-1:0]      x_issue_register_read_i,
    output logic                 x_commit_valid_o,
    output logic [IdWidth-1:0]   x_commit_id_o,
    output logic                 x_commit_kill_o,
    input  logic                 x_result_valid_i,
    output logic                 x_result_ready_o,
    input  logic [IdWidth-1:0]   x_result_id_i,
    input  logic [XLEN-1:0]      x_result_data_i,
    input  logic [4:0]           x_result_rd_i,
    input  logic                 x_result_we_i,
    output logic                 wb_valid_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic [4:0]           wb_rd_o,
    output logic [IdWidth-1:0]   wb_id_o,
    output logic                 illegal_o,
    output logic                 result_err_o
);

    offload_state_t        state_reg;
    logic [IdWidth-1:0]    id_reg;
    logic                  kill_reg;
    logic [31:0]           instr_reg;
    logic [NrRs*XLEN-1:0]  rs_reg;
    logic                  illegal_reg;
    logic [15:0]           reg_read_count_reg;

    // Goes high one cycle after reset release; gates both ready outputs so
    // that everything reads 0 while reset is held.
    logic                  alive_reg;

    logic                  wb_valid_reg;
    logic [XLEN-1:0]       wb_data_reg;
    logic [4:0]            wb_rd_reg;
    logic [IdWidth-1:0]    wb_id_reg;
    logic                  result_err_reg;

    logic issue_hs;
    logic sb_set;
    logic id_busy;
    logic result_busy;
    logic result_fire;
    logic result_hit;

    assign issue_hs    = (state_reg == REQ) && x_issue_ready_i;
    // A flush arriving in the handshake cycle itself also suppresses the
    // scoreboard entry, since the instruction will be committed as killed.
    assign sb_set      = issue_hs && x_issue_accept_i && x_issue_writeback_i
                         && !kill_reg && !flush_i;
    assign result_fire = x_result_valid_i && alive_reg;
    assign result_hit  = result_fire && result_busy;

    cvxif_offload_sb #(
        .IdWidth (IdWidth)
    ) u_sb (
        .clk         (clk_i),
        .rst         (rst_i),
        .set_en      (sb_set),
        .set_id      (id_reg),
        .clr_en      (result_hit),
        .clr_id      (x_result_id_i),
        .query_id    (id_reg),
        .query_busy  (id_busy),
        .lookup_id   (x_result_id_i),
        .lookup_busy (result_busy)
    );

    // ---------------- issue / commit FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg          <= IDLE;
            id_reg             <= '0;
            kill_reg           <= 1'b0;
            instr_reg          <= '0;
            rs_reg             <= '0;
            illegal_reg        <= 1'b0;
            reg_read_count_reg <= '0;
        end else begin
            illegal_reg <= 1'b0;
            if (issue_hs) begin
                reg_read_count_reg <= reg_read_count_reg
                                      + 16'($countones(x_issue_register_read_i));
            end
            case (state_reg)
                IDLE: begin
                    if (instr_valid_i && instr_ready_o) begin
                        instr_reg <= instr_i;
                        rs_reg    <= rs_i;
                        kill_reg  <= 1'b0;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // The request stays up even when killed; the kill is
                    // delivered through the commit instead.
                    if (flush_i) begin
                        kill_reg <= 1'b1;
                    end
                    if (x_issue_ready_i) begin
                        if (x_issue_accept_i) begin
                            state_reg <= COMMIT;
                        end else begin
                            // Rejected: ID is not consumed, no commit follows.
                            illegal_reg <= !(kill_reg || flush_i);
                            state_reg   <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    id_reg    <= id_reg + 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ---------------- result path ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alive_reg      <= 1'b0;
            wb_valid_reg   <= 1'b0;
            wb_data_reg    <= '0;
            wb_rd_reg      <= '0;
            wb_id_reg      <= '0;
            result_err_reg <= 1'b0;
        end else begin
            alive_reg      <= 1'b1;
            wb_valid_reg   <= result_hit && x_result_we_i;
            result_err_reg <= result_fire && !result_busy;
            if (result_hit && x_result_we_i) begin
                wb_data_reg <= x_result_data_i;
                wb_rd_reg   <= x_result_rd_i;
                wb_id_reg   <= x_result_id_i;
            end
        end
    end

    // ---------------- outputs ----------------
    assign instr_ready_o      = alive_reg && (state_reg == IDLE) && !id_busy;
    assign x_issue_valid_o    = (state_reg == REQ);
    assign x_issue_instr_o    = instr_reg;
    assign x_issue_id_o       = id_reg;
    assign x_issue_rs_o       = rs_reg;
    assign x_issue_rs_valid_o = {NrRs{state_reg == REQ}};
    assign x_commit_valid_o   = (state_reg == COMMIT);
    assign x_commit_id_o      = id_reg;
    assign x_commit_kill_o    = (state_reg == COMMIT) && (kill_reg || flush_i);
    assign x_result_ready_o   = alive_reg;
    assign wb_valid_o         = wb_valid_reg;
    assign wb_data_o          = wb_data_reg;
    assign wb_rd_o            = wb_rd_reg;
    assign wb_id_o            = wb_id_reg;
    assign illegal_o          = illegal_reg;
    assign result_err_o       = result_err_reg;

endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cvxif_offload_ctrl
// Self-checking bench for cvxif_offload_ctrl. Stimulus tasks push expected
// commits, writebacks and pulses into a scoreboard; a negedge monitor pops
// and compares them as the DUT produces them. Level checks are inline.
// ---------------------------------------------------------------------------
module tb_cvxif_offload_ctrl;

    localparam int XLEN    = 32;
    localparam int NrRs    = 3;
    localparam int IdWidth = 3;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 instr_valid_i = 1'b0;
    logic                 instr_ready_o;
    logic [31:0]          instr_i = '0;
    logic [NrRs*XLEN-1:0] rs_i = '0;
    logic                 flush_i = 1'b0;
    logic                 x_issue_valid_o;
    logic                 x_issue_ready_i = 1'b0;
    logic [31:0]          x_issue_instr_o;
    logic [IdWidth-1:0]   x_issue_id_o;
    logic [NrRs*XLEN-1:0] x_issue_rs_o;
    logic [NrRs-1:0]      x_issue_rs_valid_o;
    logic                 x_issue_accept_i = 1'b0;
    logic                 x_issue_writeback_i = 1'b0;
    logic [NrRs-1:0]      x_issue_register_read_i = '0;
    logic                 x_commit_valid_o;
    logic [IdWidth-1:0]   x_commit_id_o;
    logic                 x_commit_kill_o;
    logic                 x_result_valid_i = 1'b0;
    logic                 x_result_ready_o;
    logic [IdWidth-1:0]   x_result_id_i = '0;
    logic [XLEN-1:0]      x_result_data_i = '0;
    logic [4:0]           x_result_rd_i = '0;
    logic                 x_result_we_i = 1'b0;
    logic                 wb_valid_o;
    logic [XLEN-1:0]      wb_data_o;
    logic [4:0]           wb_rd_o;
    logic [IdWidth-1:0]   wb_id_o;
    logic                 illegal_o;
    logic                 result_err_o;

    always #5 clk = ~clk;

    cvxif_offload_ctrl #(
        .XLEN    (XLEN),
        .NrRs    (NrRs),
        .IdWidth (IdWidth)
    ) dut (
        .clk_i                   (clk),
        .rst_i                   (rst_i),
        .instr_valid_i           (instr_valid_i),
        .instr_ready_o           (instr_ready_o),
        .instr_i                 (instr_i),
        .rs_i                    (rs_i),
        .flush_i                 (flush_i),
        .x_issue_valid_o         (x_issue_valid_o),
        .x_issue_ready_i         (x_issue_ready_i),
        .x_issue_instr_o         (x_issue_instr_o),
        .x_issue_id_o            (x_issue_id_o),
        .x_issue_rs_o            (x_issue_rs_o),
        .x_issue_rs_valid_o      (x_issue_rs_valid_o),
        .x_issue_accept_i        (x_issue_accept_i),
        .x_issue_writeback_i     (x_issue_writeback_i),
        .x_issue_register_read_i (x_issue_register_read_i),
        .x_commit_valid_o        (x_commit_valid_o),
        .x_commit_id_o           (x_commit_id_o),
        .x_commit_kill_o         (x_commit_kill_o),
        .x_result_valid_i        (x_result_valid_i),
        .x_result_ready_o        (x_result_ready_o),
        .x_result_id_i           (x_result_id_i),
        .x_result_data_i         (x_result_data_i),
        .x_result_rd_i           (x_result_rd_i),
        .x_result_we_i           (x_result_we_i),
        .wb_valid_o              (wb_valid_o),
        .wb_data_o               (wb_data_o),
        .wb_rd_o                 (wb_rd_o),
        .wb_id_o                 (wb_id_o),
        .illegal_o               (illegal_o),
        .result_err_o            (result_err_o)
    );

    int checks = 0;
    int passed = 0;

    // Scoreboard
    logic [IdWidth:0]             exp_commit_q [$];  // {id, kill}
    logic [XLEN+5+IdWidth-1:0]    exp_wb_q     [$];  // {data, rd, id}
    int                           exp_illegal = 0;
    int                           exp_err     = 0;

    // Reference model state
    logic [IdWidth-1:0]           m_id   = '0;
    logic [(1<<IdWidth)-1:0]      m_busy = '0;

    logic [IdWidth:0]             mon_c;
    logic [XLEN+5+IdWidth-1:0]    mon_w;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (x_commit_valid_o) begin
            checks++;
            if (exp_commit_q.size() == 0) begin
                $display("FAIL commit_unexpected: got id=%0d kill=%0d, required no commit",
                         x_commit_id_o, x_commit_kill_o);
            end else begin
                mon_c = exp_commit_q.pop_front();
                if ({x_commit_id_o, x_commit_kill_o} !== mon_c)
                    $display("FAIL commit: got id=%0d kill=%0d, required id=%0d kill=%0d",
                             x_commit_id_o, x_commit_kill_o, mon_c[IdWidth:1], mon_c[0]);
                else
                    passed++;
            end
        end
        if (wb_valid_o) begin
            checks++;
            if (exp_wb_q.size() == 0) begin
                $display("FAIL wb_unexpected: got data=%h rd=%0d id=%0d, required no writeback",
                         wb_data_o, wb_rd_o, wb_id_o);
            end else begin
                mon_w = exp_wb_q.pop_front();
                if ({wb_data_o, wb_rd_o, wb_id_o} !== mon_w)
                    $display("FAIL wb: got data=%h rd=%0d id=%0d, required data=%h rd=%0d id=%0d",
                             wb_data_o, wb_rd_o, wb_id_o, mon_w[XLEN+5+IdWidth-1:5+IdWidth],
                             mon_w[5+IdWidth-1:IdWidth], mon_w[IdWidth-1:0]);
                else
                    passed++;
            end
        end
        if (illegal_o) begin
            checks++;
            if (exp_illegal == 0) begin
                $display("FAIL illegal_unexpected: got illegal_o=1, required 0");
            end else begin
                exp_illegal--;
                passed++;
            end
        end
        if (result_err_o) begin
            checks++;
            if (exp_err == 0) begin
                $display("FAIL result_err_unexpected: got result_err_o=1, required 0");
            end else begin
                exp_err--;
                passed++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model update for one candidate that will be issued.
    task automatic expect_issue(input logic acc, input logic wb, input logic kill);
        if (acc) begin
            exp_commit_q.push_back({m_id, kill});
            if (wb && !kill) m_busy[m_id] = 1'b1;
            m_id = m_id + 1'b1;
        end else if (!kill) begin
            exp_illegal++;
        end
    endtask

    // Drives one candidate through IDLE -> REQ (-> COMMIT). Returns in IDLE.
    task automatic do_issue(input logic [31:0] ins, input logic acc, input logic wb,
                            input logic flush, input int delay);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        rs_i          = {ins ^ 32'h3333_3333, ins ^ 32'h2222_2222, ins ^ 32'h1111_1111};
        cyc();
        instr_valid_i = 1'b0;
        flush_i       = flush;
        repeat (delay) cyc();
        x_issue_ready_i         = 1'b1;
        x_issue_accept_i        = acc;
        x_issue_writeback_i     = wb;
        x_issue_register_read_i = '1;
        cyc();
        flush_i                 = 1'b0;
        x_issue_ready_i         = 1'b0;
        x_issue_accept_i        = 1'b0;
        x_issue_writeback_i     = 1'b0;
        x_issue_register_read_i = '0;
        if (acc) cyc();
    endtask

    // Drives one result for one cycle and records what it should produce.
    task automatic send_result(input logic [IdWidth-1:0] id, input logic [XLEN-1:0] d,
                               input logic [4:0] rd, input logic we);
        x_result_valid_i = 1'b1;
        x_result_id_i    = id;
        x_result_data_i  = d;
        x_result_rd_i    = rd;
        x_result_we_i    = we;
        if (m_busy[id]) begin
            m_busy[id] = 1'b0;
            if (we) exp_wb_q.push_back({d, rd, id});
        end else begin
            exp_err++;
        end
        cyc();
        x_result_valid_i = 1'b0;
        x_result_we_i    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #1 rst_i = 1'b1;
        cyc(2);
        checks++;
        if ({instr_ready_o, x_issue_valid_o, x_issue_rs_valid_o, x_commit_valid_o,
             x_commit_kill_o, x_result_ready_o, wb_valid_o, illegal_o, result_err_o,
             x_issue_id_o, x_commit_id_o} !== '0)
            $display("FAIL reset_outputs: got ready=%b ivalid=%b cvalid=%b rready=%b wb=%b, required all 0",
                     instr_ready_o, x_issue_valid_o, x_commit_valid_o, x_result_ready_o, wb_valid_o);
        else passed++;
        rst_i = 1'b0;
        checks++;
        if ({x_result_ready_o, instr_ready_o} !== 2'b00)
            $display("FAIL reset_release_same_cycle: got result_ready=%b instr_ready=%b, required 0 0",
                     x_result_ready_o, instr_ready_o);
        else passed++;
        cyc();
        checks++;
        if ({x_result_ready_o, instr_ready_o} !== 2'b11)
            $display("FAIL reset_release_next_cycle: got result_ready=%b instr_ready=%b, required 1 1",
                     x_result_ready_o, instr_ready_o);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_add;
        logic [31:0]          ins;
        logic [NrRs*XLEN-1:0] ops;
        ins = 32'h0062_82ab;
        ops = {32'h0000_0003, 32'h0000_0005, 32'h0000_0002};
        expect_issue(1'b1, 1'b1, 1'b0);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        rs_i          = ops;
        checks++;
        if (instr_ready_o !== 1'b1) $display("FAIL add_ready_c0: got %b, required 1", instr_ready_o);
        else passed++;
        cyc();
        instr_valid_i           = 1'b0;
        x_issue_ready_i         = 1'b1;
        x_issue_accept_i        = 1'b1;
        x_issue_writeback_i     = 1'b1;
        x_issue_register_read_i = 3'b011;
        checks++;
        if ({x_issue_valid_o, x_issue_rs_valid_o, instr_ready_o} !== 5'b1_111_0)
            $display("FAIL add_issue_valid: got valid=%b rs_valid=%b ready=%b, required 1 111 0",
                     x_issue_valid_o, x_issue_rs_valid_o, instr_ready_o);
        else passed++;
        checks++;
        if ({x_issue_instr_o, x_issue_id_o, x_issue_rs_o} !== {ins, 3'd0, ops})
            $display("FAIL add_issue_payload: got instr=%h id=%0d rs=%h, required instr=%h id=0 rs=%h",
                     x_issue_instr_o, x_issue_id_o, x_issue_rs_o, ins, ops);
        else passed++;
        cyc();
        x_issue_ready_i         = 1'b0;
        x_issue_accept_i        = 1'b0;
        x_issue_writeback_i     = 1'b0;
        x_issue_register_read_i = '0;
        checks++;
        if (instr_ready_o !== 1'b0) $display("FAIL add_ready_commit: got %b, required 0", instr_ready_o);
        else passed++;
        cyc();
        checks++;
        if (instr_ready_o !== 1'b1) $display("FAIL add_ready_c3: got %b, required 1", instr_ready_o);
        else passed++;
        send_result(3'd0, 32'h0000_0007, 5'd5, 1'b1);
        cyc();
        $display("test_add done");
    endtask

    task automatic test_illegal;
        logic [IdWidth-1:0] id_before;
        id_before = m_id;
        expect_issue(1'b0, 1'b1, 1'b0);
        do_issue(32'hdead_000b, 1'b0, 1'b1, 1'b0, 0);
        checks++;
        if ({x_issue_id_o, instr_ready_o} !== {id_before, 1'b1})
            $display("FAIL illegal_id_kept: got id=%0d ready=%b, required id=%0d ready=1",
                     x_issue_id_o, instr_ready_o, id_before);
        else passed++;
        // Next candidate reuses the same ID (commit monitor checks it).
        expect_issue(1'b1, 1'b0, 1'b0);
        do_issue(32'h1234_000b, 1'b1, 1'b0, 1'b0, 0);
        cyc();
        $display("test_illegal done");
    endtask

    task automatic test_flush;
        logic [IdWidth-1:0] fid;
        logic [31:0]        ins;
        ins = 32'hf1f1_002b;
        fid = m_id;
        expect_issue(1'b1, 1'b1, 1'b1);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        cyc();
        instr_valid_i = 1'b0;
        flush_i       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({x_issue_valid_o, x_issue_instr_o} !== {1'b1, ins})
                $display("FAIL flush_hold_%0d: got valid=%b instr=%h, required 1 %h",
                         i, x_issue_valid_o, x_issue_instr_o, ins);
            else passed++;
            cyc();
            flush_i = 1'b0;
        end
        x_issue_ready_i     = 1'b1;
        x_issue_accept_i    = 1'b1;
        x_issue_writeback_i = 1'b1;
        cyc();
        x_issue_ready_i     = 1'b0;
        x_issue_accept_i    = 1'b0;
        x_issue_writeback_i = 1'b0;
        cyc();
        // Flushed ID must not be outstanding: its result is an error.
        send_result(fid, 32'h0000_00ff, 5'd1, 1'b1);
        cyc();
        $display("test_flush done");
    endtask

    task automatic test_wrap;
        while (m_id != '0) begin
            expect_issue(1'b1, 1'b0, 1'b0);
            do_issue(32'h0000_100b, 1'b1, 1'b0, 1'b0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            expect_issue(1'b1, 1'b1, 1'b0);
            do_issue(32'h0000_200b + i, 1'b1, 1'b1, 1'b0, 0);
        end
        checks++;
        if ({instr_ready_o, x_issue_id_o} !== {1'b0, 3'd0})
            $display("FAIL wrap_full: got ready=%b id=%0d, required ready=0 id=0",
                     instr_ready_o, x_issue_id_o);
        else passed++;
        instr_valid_i = 1'b1;
        cyc();
        instr_valid_i = 1'b0;
        checks++;
        if (x_issue_valid_o !== 1'b0)
            $display("FAIL wrap_blocked: got x_issue_valid=%b, required 0", x_issue_valid_o);
        else passed++;
        x_result_valid_i = 1'b1;
        x_result_id_i    = 3'd0;
        x_result_data_i  = 32'h0000_00a5;
        x_result_rd_i    = 5'd7;
        x_result_we_i    = 1'b1;
        m_busy[0]        = 1'b0;
        exp_wb_q.push_back({32'h0000_00a5, 5'd7, 3'd0});
        checks++;
        if (instr_ready_o !== 1'b0)
            $display("FAIL wrap_ready_result_cycle: got %b, required 0", instr_ready_o);
        else passed++;
        cyc();
        x_result_valid_i = 1'b0;
        x_result_we_i    = 1'b0;
        checks++;
        if (instr_ready_o !== 1'b1)
            $display("FAIL wrap_ready_after_free: got %b, required 1", instr_ready_o);
        else passed++;
        $display("test_wrap done");
    endtask

    task automatic test_back_to_back;
        // Issue id 0 while the result for id 1 lands in its handshake cycle.
        expect_issue(1'b1, 1'b1, 1'b0);
        fork
            do_issue(32'h0000_300b, 1'b1, 1'b1, 1'b0, 0);
            begin
                cyc();
                send_result(3'd1, 32'h1111_0001, 5'd9, 1'b1);
            end
        join
        checks++;
        if (instr_ready_o !== !m_busy[m_id])
            $display("FAIL set_clear_same_cycle: got ready=%b, required %b",
                     instr_ready_o, !m_busy[m_id]);
        else passed++;
        // Retire the rest; even IDs silently (we=0), odd IDs with writeback.
        for (int i = 2; i < 8; i++)
            send_result(3'(i), 32'hc0de_0000 + i, 5'(i + 10), i[0]);
        send_result(3'd0, 32'h0000_0abc, 5'd31, 1'b1);
        cyc();
        $display("test_back_to_back done");
    endtask

    task automatic test_result_err;
        send_result(3'd3, 32'h0000_0033, 5'd3, 1'b1);
        checks++;
        if ({result_err_o, wb_valid_o} !== 2'b10)
            $display("FAIL result_err_pulse: got err=%b wb_valid=%b, required 1 0",
                     result_err_o, wb_valid_o);
        else passed++;
        cyc();
        checks++;
        if (result_err_o !== 1'b0)
            $display("FAIL result_err_single: got %b, required 0", result_err_o);
        else passed++;
        $display("test_result_err done");
    endtask

    task automatic test_reset_mid;
        logic [IdWidth-1:0] old_id;
        old_id = m_id;
        for (int i = 0; i < 2; i++) begin
            expect_issue(1'b1, 1'b1, 1'b0);
            do_issue(32'h0000_400b + i, 1'b1, 1'b1, 1'b0, 0);
        end
        instr_valid_i = 1'b1;
        instr_i       = 32'h5555_000b;
        cyc();
        instr_valid_i = 1'b0;
        checks++;
        if (x_issue_valid_o !== 1'b1)
            $display("FAIL reset_mid_in_req: got x_issue_valid=%b, required 1", x_issue_valid_o);
        else passed++;
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({instr_ready_o, x_issue_valid_o, x_issue_rs_valid_o, x_commit_valid_o,
             x_commit_kill_o, x_result_ready_o, wb_valid_o, illegal_o, result_err_o,
             x_issue_id_o, x_issue_instr_o} !== '0)
            $display("FAIL reset_mid_outputs: got ivalid=%b id=%0d instr=%h rready=%b, required all 0",
                     x_issue_valid_o, x_issue_id_o, x_issue_instr_o, x_result_ready_o);
        else passed++;
        cyc();
        rst_i  = 1'b0;
        m_id   = '0;
        m_busy = '0;
        cyc();
        send_result(old_id, 32'h0000_0077, 5'd4, 1'b1);
        checks++;
        if ({result_err_o, wb_valid_o} !== 2'b10)
            $display("FAIL reset_mid_late_result: got err=%b wb_valid=%b, required 1 0",
                     result_err_o, wb_valid_o);
        else passed++;
        cyc();
        $display("test_reset_mid done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_illegal();
        test_flush();
        test_wrap();
        test_back_to_back();
        test_result_err();
        test_reset_mid();
        cyc(2);
        checks++;
        if (exp_commit_q.size() !== 0)
            $display("FAIL commit_drain: got %0d commits missing, required 0", exp_commit_q.size());
        else passed++;
        checks++;
        if (exp_wb_q.size() !== 0)
            $display("FAIL wb_drain: got %0d writebacks missing, required 0", exp_wb_q.size());
        else passed++;
        checks++;
        if (exp_illegal !== 0)
            $display("FAIL illegal_drain: got %0d pulses missing, required 0", exp_illegal);
        else passed++;
        checks++;
        if (exp_err !== 0)
            $display("FAIL result_err_drain: got %0d pulses missing, required 0", exp_err);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
